// File: rtl/pattern_bus_driver_if.sv
// Pattern word handshake, byte-beat bus and match-count readback for pattern_bus_driver.
// PATTERN_REPEAT_EN adds the REPEAT control signal.
interface pattern_bus_driver_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      WORD_IN;
   logic             WORD_VALID;
   logic             WORD_READY;
   logic [1:0]       ABUS;
   logic [7:0]       DBUS;
   logic             BSTB;
   logic             BUSY;
   logic             WREN;
   logic [CNT_W-1:0] MATCH_CNT;
`ifdef PATTERN_REPEAT_EN
   logic             REPEAT;

   modport master (
      input  WORD_IN, WORD_VALID, WREN, REPEAT,
      output WORD_READY, ABUS, DBUS, BSTB, BUSY, MATCH_CNT
   );
   modport slave (
      output WORD_IN, WORD_VALID, WREN, REPEAT,
      input  WORD_READY, ABUS, DBUS, BSTB, BUSY, MATCH_CNT
   );
`else
   modport master (
      input  WORD_IN, WORD_VALID, WREN,
      output WORD_READY, ABUS, DBUS, BSTB, BUSY, MATCH_CNT
   );
   modport slave (
      output WORD_IN, WORD_VALID, WREN,
      input  WORD_READY, ABUS, DBUS, BSTB, BUSY, MATCH_CNT
   );
`endif
endinterface

// File: rtl/pattern_bus_driver.sv
// Serialises 32-bit pattern words into ABUS/DBUS byte beats and counts WREN matches.
// Optional word repetition is enabled by defining PATTERN_REPEAT_EN.
module pattern_bus_driver #(
   parameter int NUM_BEATS  = 4,
   parameter int GAP_CYCLES = 1,
   parameter int CNT_W      = 16
) (
   input logic                  CLK,
   input logic                  RST,
   pattern_bus_driver_if.master bus
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_BEAT    = 2'd1;
   localparam logic [1:0] S_GAP     = 2'd2;
   localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);
   localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);

   logic [1:0]       state_q, state_d;
   logic [1:0]       beat_q, beat_d;
   logic [3:0]       gap_q, gap_d;
   logic [31:0]      word_q, word_d;
   logic [1:0]       abus_q, abus_d;
   logic [7:0]       dbus_q, dbus_d;
   logic             bstb_q, bstb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             enter_beat;
   logic             repeat_en;
   logic [31:0]      word_src;
   logic [7:0]       lane_bytes [4];

`ifdef PATTERN_REPEAT_EN
   assign repeat_en = bus.REPEAT;
`else
   assign repeat_en = 1'b0;
`endif

   // In IDLE the byte about to go out comes straight from the accepted input word.
   assign word_src = (state_q == S_IDLE) ? bus.WORD_IN : word_q;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_bytes[gi] = word_src[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      gap_d      = gap_q;
      word_d     = word_q;
      abus_d     = abus_q;
      dbus_d     = dbus_q;
      bstb_d     = 1'b0;
      enter_beat = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.WORD_VALID) begin
               word_d     = bus.WORD_IN;
               beat_d     = 2'd0;
               enter_beat = 1'b1;
            end
         end
         S_BEAT: begin
            if (beat_q == LAST_BEAT && !repeat_en) begin
               state_d = S_IDLE;
            end else begin
               beat_d = (beat_q == LAST_BEAT) ? 2'd0 : beat_q + 2'd1;
               if (GAP_CYCLES == 0) begin
                  enter_beat = 1'b1;
               end else begin
                  state_d = S_GAP;
                  gap_d   = GAP_LOAD;
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - 4'd1;
            if (gap_q == 4'd1) enter_beat = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // Outputs are loaded on the edge that enters BEAT, so they are registered.
      if (enter_beat) begin
         state_d = S_BEAT;
         abus_d  = beat_d;
         dbus_d  = lane_bytes[beat_d];
         bstb_d  = 1'b1;
      end
   end

   assign cnt_d = (bus.WREN && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         beat_q  <= 2'd0;
         gap_q   <= 4'd0;
         word_q  <= 32'd0;
         abus_q  <= 2'd0;
         dbus_q  <= 8'd0;
         bstb_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
         word_q  <= word_d;
         abus_q  <= abus_d;
         dbus_q  <= dbus_d;
         bstb_q  <= bstb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.WORD_READY = (state_q == S_IDLE) && !RST;
   assign bus.BUSY       = (state_q != S_IDLE);
   assign bus.ABUS       = abus_q;
   assign bus.DBUS       = dbus_q;
   assign bus.BSTB       = bstb_q;
   assign bus.MATCH_CNT  = cnt_q;
endmodule
